loop_status_monitor: RTL and testbench



---
 rtl/loop_status_pkg.sv | 36 +++
 rtl/loop_status_monitor_fsm_event_detect.sv | 21 ++
 rtl/loop_status_monitor.sv | 221 ++++++++++++++++++++++
 tb/tb_loop_status_monitor.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/loop_status_pkg.sv
`default_nettype none
// ============================================================================
// Module   : loop_status_pkg
// Purpose  : Shared types and helpers for the loop status monitor: FSM state
//            enums, loop event-kind indices and a saturating increment.
// Revision : 1.0  initial release
// ============================================================================
package loop_status_pkg;

    // Block-level handshake tracker states
    typedef enum logic [0:0] {
        MOD_IDLE = 1'b0,
        MOD_BUSY = 1'b1
    } mod_state_t;

    // Loop invocation tracker states
    typedef enum logic [0:0] {
        LOOP_IDLE = 1'b0,
        LOOP_RUN  = 1'b1
    } loop_state_t;

    // Indices of the decoded loop events inside the event vector
    localparam int c_ev_iter_start = 0;
    localparam int c_ev_iter_end   = 1;
    localparam int c_ev_quit       = 2;
    localparam int c_ev_count      = 3;

    // Increment a value that is 'width' bits wide, sticking at all-ones
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
        logic [63:0] v_max;
        v_max = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
        return (value >= v_max) ? v_max : value + 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/loop_status_monitor_fsm_event_detect.sv
`default_nettype none
// ============================================================================
// Module   : fsm_event_detect
// Purpose  : Decodes one pipeline-FSM event: the loop FSM sits in the
//            reference state, the stage is not stalled and is enabled.
// Revision : 1.0  initial release
// ============================================================================
module fsm_event_detect #(
    parameter int STATE_W = 1
) (
    input  logic [STATE_W-1:0] cur_state,
    input  logic [STATE_W-1:0] ref_state,
    input  logic               block,
    input  logic               enable,
    output logic               fire
);

    assign fire = (cur_state == ref_state) & ~block & enable;

endmodule
`default_nettype wire

// File: rtl/loop_status_monitor.sv
`default_nettype none
// ============================================================================
// Module   : loop_status_monitor
// Purpose  : Passive run-time monitor for an HLS block handshake and one of
//            its pipelined loops. Keeps saturating transaction, latency,
//            invocation and iteration statistics; freezes on finish.
// Revision : 1.0  initial release
// ============================================================================
module loop_status_monitor #(
    parameter int STATE_W = 1,
    parameter int CNT_W   = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               mod_start,
    input  logic               mod_ready,
    input  logic               mod_done,
    input  logic               mod_continue,
    input  logic [STATE_W-1:0] loop_cur_state,
    input  logic [STATE_W-1:0] loop_iter_start_state,
    input  logic [STATE_W-1:0] loop_iter_end_state,
    input  logic [STATE_W-1:0] loop_quit_state,
    input  logic               loop_iter_start_block,
    input  logic               loop_iter_end_block,
    input  logic               loop_quit_block,
    input  logic               loop_iter_start_enable,
    input  logic               loop_iter_end_enable,
    input  logic               loop_quit_enable,
    input  logic               loop_start,
    input  logic               loop_ready,
    input  logic               loop_done,
    input  logic               loop_continue,
    input  logic               loop_quit_at_end,
    input  logic               finish,
    output logic               mod_busy,
    output logic [CNT_W-1:0]   mod_txn_count,
    output logic [CNT_W-1:0]   mod_last_latency,
    output logic [CNT_W-1:0]   mod_max_latency,
    output logic               mod_done_pulse,
    output logic               loop_active,
    output logic [CNT_W-1:0]   loop_invocations,
    output logic [CNT_W-1:0]   loop_iter_count,
    output logic [CNT_W-1:0]   loop_iter_total,
    output logic [CNT_W-1:0]   loop_last_trip,
    output logic               loop_done_pulse,
    output logic               finished
);

    import loop_status_pkg::*;

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] value);
        return CNT_W'(sat_inc(64'(value), CNT_W));
    endfunction

    mod_state_t          r_mod_state;
    loop_state_t         r_loop_state;
    logic                r_finished;
    logic [CNT_W-1:0]    r_lat;
    logic [CNT_W-1:0]    r_txn;
    logic [CNT_W-1:0]    r_last_lat;
    logic [CNT_W-1:0]    r_max_lat;
    logic                r_mod_pulse;
    logic [CNT_W-1:0]    r_invocations;
    logic [CNT_W-1:0]    r_iter_count;
    logic [CNT_W-1:0]    r_iter_total;
    logic [CNT_W-1:0]    r_last_trip;
    logic                r_loop_pulse;

    logic [c_ev_count-1:0] w_ev;
    logic                  w_mod_accept;
    logic                  w_mod_complete;
    logic                  w_mod_record;
    logic [CNT_W-1:0]      w_rec_lat;
    logic                  w_loop_complete;
    logic [CNT_W-1:0]      w_trip;
    logic                  w_unused_loop_ready;

    fsm_event_detect #(.STATE_W(STATE_W)) u_ev_iter_start (
        .cur_state (loop_cur_state),
        .ref_state (loop_iter_start_state),
        .block     (loop_iter_start_block),
        .enable    (loop_iter_start_enable),
        .fire      (w_ev[c_ev_iter_start])
    );

    fsm_event_detect #(.STATE_W(STATE_W)) u_ev_iter_end (
        .cur_state (loop_cur_state),
        .ref_state (loop_iter_end_state),
        .block     (loop_iter_end_block),
        .enable    (loop_iter_end_enable),
        .fire      (w_ev[c_ev_iter_end])
    );

    fsm_event_detect #(.STATE_W(STATE_W)) u_ev_quit (
        .cur_state (loop_cur_state),
        .ref_state (loop_quit_state),
        .block     (loop_quit_block),
        .enable    (loop_quit_enable),
        .fire      (w_ev[c_ev_quit])
    );

    // loop_ready carries nothing the statistics depend on
    assign w_unused_loop_ready = loop_ready;

    assign w_mod_accept    = mod_start & mod_ready;
    assign w_mod_complete  = mod_done & mod_continue;
    assign w_loop_complete = loop_done & loop_continue;

    // A completion counts when a transaction is in flight or is accepted in the same cycle
    assign w_mod_record = w_mod_complete & ((r_mod_state == MOD_BUSY) | w_mod_accept);
    assign w_rec_lat    = (r_mod_state == MOD_BUSY) ? r_lat : '0;

    // Trip count including an iteration starting in this very cycle
    assign w_trip = w_ev[c_ev_iter_start] ? inc(r_iter_count) : r_iter_count;

    // Sticky end-of-run flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_finished <= 1'b0;
        end else if (finish) begin
            r_finished <= 1'b1;
        end
    end

    // Block handshake tracker: busy state, latency counter and statistics
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_mod_state <= MOD_IDLE;
            r_lat       <= '0;
            r_txn       <= '0;
            r_last_lat  <= '0;
            r_max_lat   <= '0;
            r_mod_pulse <= 1'b0;
        end else if (r_finished) begin
            r_mod_pulse <= 1'b0;
        end else begin
            r_mod_pulse <= w_mod_record;
            if (w_mod_record) begin
                r_last_lat <= w_rec_lat;
                r_txn      <= inc(r_txn);
                if (w_rec_lat > r_max_lat) begin
                    r_max_lat <= w_rec_lat;
                end
            end
            case (r_mod_state)
                MOD_IDLE: begin
                    if (w_mod_accept && !w_mod_complete) begin
                        r_mod_state <= MOD_BUSY;
                        r_lat       <= c_one;
                    end
                end
                MOD_BUSY: begin
                    if (w_mod_complete && w_mod_accept) begin
                        r_lat <= c_one;
                    end else if (w_mod_complete) begin
                        r_mod_state <= MOD_IDLE;
                    end else begin
                        r_lat <= inc(r_lat);
                    end
                end
                default: r_mod_state <= MOD_IDLE;
            endcase
        end
    end

    // Loop invocation tracker: iteration counts, trip length and invocations
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_loop_state  <= LOOP_IDLE;
            r_invocations <= '0;
            r_iter_count  <= '0;
            r_iter_total  <= '0;
            r_last_trip   <= '0;
            r_loop_pulse  <= 1'b0;
        end else if (r_finished) begin
            r_loop_pulse <= 1'b0;
        end else begin
            r_loop_pulse <= 1'b0;
            case (r_loop_state)
                LOOP_IDLE: begin
                    if (loop_start) begin
                        r_loop_state <= LOOP_RUN;
                        r_iter_count <= w_ev[c_ev_iter_start] ? c_one : '0;
                    end
                end
                LOOP_RUN: begin
                    r_iter_count <= w_trip;
                    if (w_ev[c_ev_iter_end]) begin
                        r_iter_total <= inc(r_iter_total);
                    end
                    if (w_loop_complete) begin
                        r_last_trip   <= w_trip;
                        r_invocations <= inc(r_invocations);
                        r_loop_pulse  <= 1'b1;
                        r_loop_state  <= LOOP_IDLE;
                    end else if (w_ev[c_ev_quit] && loop_quit_at_end && !loop_done) begin
                        r_last_trip <= w_trip;
                    end
                end
                default: r_loop_state <= LOOP_IDLE;
            endcase
        end
    end

    assign mod_busy         = (r_mod_state == MOD_BUSY);
    assign mod_txn_count    = r_txn;
    assign mod_last_latency = r_last_lat;
    assign mod_max_latency  = r_max_lat;
    assign mod_done_pulse   = r_mod_pulse;
    assign loop_active      = (r_loop_state == LOOP_RUN);
    assign loop_invocations = r_invocations;
    assign loop_iter_count  = r_iter_count;
    assign loop_iter_total  = r_iter_total;
    assign loop_last_trip   = r_last_trip;
    assign loop_done_pulse  = r_loop_pulse;
    assign finished         = r_finished;

endmodule
`default_nettype wire

// File: tb/tb_loop_status_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_loop_status_monitor
// Purpose  : Self-checking bench for loop_status_monitor at two counter
//            widths, against a timestamp-based reference model.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_loop_status_monitor;

    localparam int STATE_W = 1;
    localparam int BIG_W   = 32;
    localparam int SMALL_W = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic mod_start, mod_ready, mod_done, mod_continue;
    logic [STATE_W-1:0] loop_cur_state, loop_iter_start_state, loop_iter_end_state, loop_quit_state;
    logic loop_iter_start_block, loop_iter_end_block, loop_quit_block;
    logic loop_iter_start_enable, loop_iter_end_enable, loop_quit_enable;
    logic loop_start, loop_ready, loop_done, loop_continue, loop_quit_at_end, finish;

    logic               b_busy, b_mpulse, b_active, b_lpulse, b_fin;
    logic [BIG_W-1:0]   b_txn, b_last, b_max, b_inv, b_icnt, b_itot, b_trip;
    logic               s_busy, s_mpulse, s_active, s_lpulse, s_fin;
    logic [SMALL_W-1:0] s_txn, s_last, s_max, s_inv, s_icnt, s_itot, s_trip;

    loop_status_monitor #(.STATE_W(STATE_W), .CNT_W(BIG_W)) dut (
        .clock(clock), .reset(reset),
        .mod_start(mod_start), .mod_ready(mod_ready), .mod_done(mod_done), .mod_continue(mod_continue),
        .loop_cur_state(loop_cur_state), .loop_iter_start_state(loop_iter_start_state),
        .loop_iter_end_state(loop_iter_end_state), .loop_quit_state(loop_quit_state),
        .loop_iter_start_block(loop_iter_start_block), .loop_iter_end_block(loop_iter_end_block),
        .loop_quit_block(loop_quit_block), .loop_iter_start_enable(loop_iter_start_enable),
        .loop_iter_end_enable(loop_iter_end_enable), .loop_quit_enable(loop_quit_enable),
        .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
        .loop_continue(loop_continue), .loop_quit_at_end(loop_quit_at_end), .finish(finish),
        .mod_busy(b_busy), .mod_txn_count(b_txn), .mod_last_latency(b_last), .mod_max_latency(b_max),
        .mod_done_pulse(b_mpulse), .loop_active(b_active), .loop_invocations(b_inv),
        .loop_iter_count(b_icnt), .loop_iter_total(b_itot), .loop_last_trip(b_trip),
        .loop_done_pulse(b_lpulse), .finished(b_fin)
    );

    loop_status_monitor #(.STATE_W(STATE_W), .CNT_W(SMALL_W)) dut_small (
        .clock(clock), .reset(reset),
        .mod_start(mod_start), .mod_ready(mod_ready), .mod_done(mod_done), .mod_continue(mod_continue),
        .loop_cur_state(loop_cur_state), .loop_iter_start_state(loop_iter_start_state),
        .loop_iter_end_state(loop_iter_end_state), .loop_quit_state(loop_quit_state),
        .loop_iter_start_block(loop_iter_start_block), .loop_iter_end_block(loop_iter_end_block),
        .loop_quit_block(loop_quit_block), .loop_iter_start_enable(loop_iter_start_enable),
        .loop_iter_end_enable(loop_iter_end_enable), .loop_quit_enable(loop_quit_enable),
        .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
        .loop_continue(loop_continue), .loop_quit_at_end(loop_quit_at_end), .finish(finish),
        .mod_busy(s_busy), .mod_txn_count(s_txn), .mod_last_latency(s_last), .mod_max_latency(s_max),
        .mod_done_pulse(s_mpulse), .loop_active(s_active), .loop_invocations(s_inv),
        .loop_iter_count(s_icnt), .loop_iter_total(s_itot), .loop_last_trip(s_trip),
        .loop_done_pulse(s_lpulse), .finished(s_fin)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: unbounded counts, saturation applied when comparing
    longint m_cycle, m_acc, m_txn, m_last, m_max;
    longint m_cur, m_total, m_inv, m_trip;
    bit     m_busy, m_mpulse, m_active, m_lpulse, m_fin;

    function automatic longint sat(input longint value, input int width);
        longint v_max;
        v_max = (longint'(1) << width) - 1;
        return (value > v_max) ? v_max : value;
    endfunction

    task automatic check_value(input string tag, input longint actual, input longint expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic check_all();
        check_value("busy",       longint'(b_busy),   longint'(m_busy));
        check_value("txn",        longint'(b_txn),    sat(m_txn, BIG_W));
        check_value("last_lat",   longint'(b_last),   sat(m_last, BIG_W));
        check_value("max_lat",    longint'(b_max),    sat(m_max, BIG_W));
        check_value("mod_pulse",  longint'(b_mpulse), longint'(m_mpulse));
        check_value("active",     longint'(b_active), longint'(m_active));
        check_value("invoc",      longint'(b_inv),    sat(m_inv, BIG_W));
        check_value("iter_cnt",   longint'(b_icnt),   sat(m_cur, BIG_W));
        check_value("iter_tot",   longint'(b_itot),   sat(m_total, BIG_W));
        check_value("last_trip",  longint'(b_trip),   sat(m_trip, BIG_W));
        check_value("loop_pulse", longint'(b_lpulse), longint'(m_lpulse));
        check_value("finished",   longint'(b_fin),    longint'(m_fin));
        check_value("w4_busy",       longint'(s_busy),   longint'(m_busy));
        check_value("w4_txn",        longint'(s_txn),    sat(m_txn, SMALL_W));
        check_value("w4_last_lat",   longint'(s_last),   sat(m_last, SMALL_W));
        check_value("w4_max_lat",    longint'(s_max),    sat(m_max, SMALL_W));
        check_value("w4_mod_pulse",  longint'(s_mpulse), longint'(m_mpulse));
        check_value("w4_active",     longint'(s_active), longint'(m_active));
        check_value("w4_invoc",      longint'(s_inv),    sat(m_inv, SMALL_W));
        check_value("w4_iter_cnt",   longint'(s_icnt),   sat(m_cur, SMALL_W));
        check_value("w4_iter_tot",   longint'(s_itot),   sat(m_total, SMALL_W));
        check_value("w4_last_trip",  longint'(s_trip),   sat(m_trip, SMALL_W));
        check_value("w4_loop_pulse", longint'(s_lpulse), longint'(m_lpulse));
        check_value("w4_finished",   longint'(s_fin),    longint'(m_fin));
    endtask

    task automatic model_reset();
        m_cycle = 0; m_acc = 0; m_txn = 0; m_last = 0; m_max = 0;
        m_cur = 0; m_total = 0; m_inv = 0; m_trip = 0;
        m_busy = 0; m_mpulse = 0; m_active = 0; m_lpulse = 0; m_fin = 0;
    endtask

    task automatic record(input longint lat);
        m_last = lat;
        if (lat > m_max) m_max = lat;
        m_txn++;
        m_mpulse = 1;
    endtask

    // Predict the effect of the currently driven inputs at the coming edge
    task automatic model_step();
        bit acc, cmp, ist, iend, qt, lcmp;
        m_mpulse = 0;
        m_lpulse = 0;
        m_cycle++;
        if (m_fin) return;
        acc  = mod_start && mod_ready;
        cmp  = mod_done && mod_continue;
        ist  = (loop_cur_state == loop_iter_start_state) && !loop_iter_start_block && loop_iter_start_enable;
        iend = (loop_cur_state == loop_iter_end_state) && !loop_iter_end_block && loop_iter_end_enable;
        qt   = (loop_cur_state == loop_quit_state) && !loop_quit_block && loop_quit_enable;
        lcmp = loop_done && loop_continue;
        if (m_busy) begin
            if (cmp) begin
                record(m_cycle - m_acc);
                if (acc) m_acc = m_cycle;
                else     m_busy = 0;
            end
        end else if (acc) begin
            if (cmp) record(0);
            else begin m_busy = 1; m_acc = m_cycle; end
        end
        if (!m_active) begin
            if (loop_start) begin m_active = 1; m_cur = ist ? 1 : 0; end
        end else begin
            if (ist)  m_cur++;
            if (iend) m_total++;
            if (lcmp) begin
                m_trip = m_cur; m_inv++; m_lpulse = 1; m_active = 0;
            end else if (qt && loop_quit_at_end && !loop_done) begin
                m_trip = m_cur;
            end
        end
        if (finish) m_fin = 1;
    endtask

    task automatic clear_inputs();
        mod_start = 0; mod_ready = 0; mod_done = 0; mod_continue = 0;
        loop_cur_state = '0; loop_iter_start_state = '0; loop_iter_end_state = '0; loop_quit_state = '0;
        loop_iter_start_block = 0; loop_iter_end_block = 0; loop_quit_block = 0;
        loop_iter_start_enable = 0; loop_iter_end_enable = 0; loop_quit_enable = 0;
        loop_start = 0; loop_ready = 0; loop_done = 0; loop_continue = 0; loop_quit_at_end = 0;
        finish = 0;
    endtask

    task automatic drive_random(input int acc_div, input int cmp_div);
        mod_start              = ($urandom_range(0, acc_div - 1) == 0);
        mod_ready              = ($urandom % 4 != 0);
        mod_done               = ($urandom_range(0, cmp_div - 1) == 0);
        mod_continue           = ($urandom % 4 != 0);
        loop_cur_state         = STATE_W'($urandom);
        loop_iter_start_state  = STATE_W'($urandom);
        loop_iter_end_state    = STATE_W'($urandom);
        loop_quit_state        = STATE_W'($urandom);
        loop_iter_start_block  = ($urandom % 4 == 0);
        loop_iter_end_block    = ($urandom % 4 == 0);
        loop_quit_block        = ($urandom % 4 == 0);
        loop_iter_start_enable = ($urandom % 4 != 0);
        loop_iter_end_enable   = ($urandom % 4 != 0);
        loop_quit_enable       = ($urandom % 4 != 0);
        loop_start             = ($urandom % 6 == 0);
        loop_ready             = ($urandom % 2 == 0);
        loop_done              = ($urandom_range(0, cmp_div - 1) == 0);
        loop_continue          = ($urandom % 4 != 0);
        loop_quit_at_end       = ($urandom % 2 == 0);
        finish                 = 0;
    endtask

    // Called at a negedge with inputs set: predict, cross the edge, compare
    task automatic cycle();
        model_step();
        @(negedge clock);
        check_all();
    endtask

    task automatic run_random(input int n, input int acc_div, input int cmp_div);
        for (int i = 0; i < n; i++) begin
            drive_random(acc_div, cmp_div);
            cycle();
        end
    endtask

    initial begin
        clear_inputs();
        model_reset();
        repeat (2) @(negedge clock);
        check_all();
        reset = 1;

        // Single transaction, latency 5
        mod_start = 1; mod_ready = 1; cycle();
        clear_inputs(); repeat (4) cycle();
        mod_done = 1; mod_continue = 1; cycle();
        clear_inputs(); cycle();

        // Back-to-back latencies 3 and 7, second accept on first completion
        mod_start = 1; mod_ready = 1; cycle();
        clear_inputs(); repeat (2) cycle();
        mod_start = 1; mod_ready = 1; mod_done = 1; mod_continue = 1; cycle();
        clear_inputs(); repeat (6) cycle();
        mod_done = 1; mod_continue = 1; cycle();
        clear_inputs(); cycle();

        // Loop with 4 unstalled iterations and one stalled cycle
        loop_start = 1; cycle();
        clear_inputs();
        loop_iter_start_enable = 1; loop_iter_end_enable = 1;
        repeat (2) cycle();
        loop_iter_start_block = 1; loop_iter_end_enable = 0; cycle();
        loop_iter_start_block = 0; loop_iter_end_enable = 1; repeat (2) cycle();
        clear_inputs(); loop_done = 1; loop_continue = 1; cycle();
        clear_inputs(); cycle();

        // Random traffic, then long latencies to exercise narrow saturation
        run_random(600, 3, 5);
        run_random(400, 2, 30);

        // Asynchronous reset while both paths are active
        for (int i = 0; i < 300; i++) begin
            if (m_busy && m_active) break;
            drive_random(2, 8);
            cycle();
        end
        #2 reset = 0;
        model_reset();
        #1 check_all();
        @(negedge clock);
        check_all();
        reset = 1;
        clear_inputs(); mod_start = 1; mod_ready = 1; cycle();
        clear_inputs(); repeat (2) cycle();
        mod_done = 1; mod_continue = 1; cycle();
        run_random(300, 3, 6);

        // Freeze on finish, then keep handshaking
        drive_random(3, 6); finish = 1; cycle();
        run_random(200, 2, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
